// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered n-bit adder among m requesters (IDLE -> EXEC -> DONE).
// Define ADDER_ARBITER_SUB_EN to add a per-requester sub input that selects X - Y.
module adder_arbiter #(
  parameter int n = 32,
  parameter int m = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [m-1:0]   req,
  input  logic [m*n-1:0] Xall,
  input  logic [m*n-1:0] Yall,
  input  logic [m-1:0]   carryin,
`ifdef ADDER_ARBITER_SUB_EN
  input  logic [m-1:0]   sub,
`endif
  output logic [m-1:0]   grant,
  output logic [m-1:0]   done,
  output logic [n-1:0]   S,
  output logic           carryout,
  output logic           overflow,
  output logic           busy,
  output logic [1:0]     state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int IW = $clog2(m);
  localparam int CW = IW + 1;

  logic [1:0]    state_q, state_d;
  logic [m-1:0]  grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_q, last_d;
  logic [n-1:0]  x_q, x_d, y_q, y_d;
  logic          cin_q, cin_d;
  logic [n-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
`ifdef ADDER_ARBITER_SUB_EN
  logic          sub_q, sub_d;
`endif

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [m-1:0]  win_oh;
  logic [CW-1:0] cand;
  logic [n-1:0]  x_sel, y_sel;
  logic          cin_sel;
  logic [n-1:0]  y_eff;
  logic          cin_eff;
  logic [n:0]    sum_full;
  logic          ovf_calc;

  // Search starts one past the last served index and wraps, so every active requester gets a turn within m ops.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    cand      = '0;
    for (int i = 1; i <= m; i++) begin
      cand = {1'b0, last_q} + CW'(i);
      if (cand >= CW'(m)) cand = cand - CW'(m);
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
    if (win_found) win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    x_sel   = '0;
    y_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < m; i++) begin
      if (win_oh[i]) begin
        x_sel   = Xall[i*n +: n];
        y_sel   = Yall[i*n +: n];
        cin_sel = carryin[i];
      end
    end
  end

  // Subtraction reuses the adder as X + ~Y + 1; overflow is judged on the effective operand.
`ifdef ADDER_ARBITER_SUB_EN
  assign y_eff   = sub_q ? ~y_q : y_q;
  assign cin_eff = sub_q ? 1'b1 : cin_q;
`else
  assign y_eff   = y_q;
  assign cin_eff = cin_q;
`endif

  assign sum_full = {1'b0, x_q} + {1'b0, y_eff} + {{n{1'b0}}, cin_eff};
  assign ovf_calc = (x_q[n-1] & y_eff[n-1] & ~sum_full[n-1]) |
                    (~x_q[n-1] & ~y_eff[n-1] & sum_full[n-1]);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    cin_d   = cin_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef ADDER_ARBITER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          grant_d = win_oh;
          gidx_d  = win_idx;
          x_d     = x_sel;
          y_d     = y_sel;
          cin_d   = cin_sel;
`ifdef ADDER_ARBITER_SUB_EN
          sub_d   = sub[win_idx];
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d     = sum_full[n-1:0];
        cout_d  = sum_full[n];
        ovf_d   = ovf_calc;
        state_d = DONE;
      end
      DONE: begin
        last_d  = gidx_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(m - 1);
      x_q     <= '0;
      y_q     <= '0;
      cin_q   <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ADDER_ARBITER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cin_q   <= cin_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef ADDER_ARBITER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Handshake: done is a one-cycle level during DONE; the owner drops req on the edge that samples it.
  assign grant     = grant_q;
  assign done      = (state_q == DONE) ? grant_q : '0;
  assign S         = s_q;
  assign carryout  = cout_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed operations push expected results, a monitor checks each done pulse.
module tb_adder_arbiter;
  localparam int N = 32;
  localparam int M = 4;
  localparam int W = M + N + 2;

  logic           Clock;
  logic           Reset;
  logic [M-1:0]   req;
  logic [M*N-1:0] Xall;
  logic [M*N-1:0] Yall;
  logic [M-1:0]   carryin;
`ifdef ADDER_ARBITER_SUB_EN
  logic [M-1:0]   sub;
`endif
  logic [M-1:0]   grant;
  logic [M-1:0]   done;
  logic [N-1:0]   S;
  logic           carryout;
  logic           overflow;
  logic           busy;
  logic [1:0]     state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adder_arbiter #(.n(N), .m(M)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .Xall(Xall), .Yall(Yall),
    .carryin(carryin),
`ifdef ADDER_ARBITER_SUB_EN
    .sub(sub),
`endif
    .grant(grant), .done(done), .S(S), .carryout(carryout),
    .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(negedge Clock) begin
    if (!Reset && (done != '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%b required=none", done);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("done_result", 64'({done, S, carryout, overflow}), 64'(e));
      end
    end
  end

  // driver tasks
  task automatic set_ops(input int idx, input logic [N-1:0] x, input logic [N-1:0] y, input logic cin);
    Xall[idx*N +: N] = x;
    Yall[idx*N +: N] = y;
    carryin[idx]     = cin;
  endtask

  task automatic push_exp(input int idx, input logic [N-1:0] es, input logic ec, input logic eo);
    logic [M-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.push_back({oh, es, ec, eo});
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  // Called on a negedge; exact-cycle checks on grant, done latency and return to idle.
  task automatic run_op(input int idx, input logic [N-1:0] x, input logic [N-1:0] y, input logic cin,
                        input logic [N-1:0] es, input logic ec, input logic eo, input bit zero_after);
    logic [M-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    push_exp(idx, es, ec, eo);
    set_ops(idx, x, y, cin);
    req[idx] = 1'b1;
    @(negedge Clock);
    check("grant", 64'(grant), 64'(oh));
    check("busy_exec", 64'(busy), 64'd1);
    check("done_early", 64'(done), 64'd0);
    if (zero_after) set_ops(idx, '0, '0, 1'b0);
    @(negedge Clock);
    check("done_latency", 64'(done), 64'(oh));
    check("grant_hold", 64'(grant), 64'(oh));
    req[idx] = 1'b0;
    @(negedge Clock);
    check("idle_done", 64'(done), 64'd0);
    check("idle_grant", 64'(grant), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic wait_done(output int at_cyc);
    int k;
    k = 0;
    while (done == '0 && k < 12) begin
      @(negedge Clock);
      k++;
    end
    at_cyc = cyc;
    if (done == '0) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=timeout required=done");
    end
  endtask

  initial begin
    int t_prev, t_now;
    Reset = 1'b1;
    req = '0;
    Xall = '0;
    Yall = '0;
    carryin = '0;
`ifdef ADDER_ARBITER_SUB_EN
    sub = '0;
`endif
    @(negedge Clock);
    @(negedge Clock);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_s", 64'(S), 64'd0);
    check("rst_cout", 64'(carryout), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    Reset = 1'b0;
    @(negedge Clock);

    // positive overflow into the sign bit
    run_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge Clock);
    check("s_hold", 64'(S), 64'h8000_0000);
    check("ovf_hold", 64'(overflow), 64'd1);

    // unsigned wrap with carry-in
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // operands cleared right after grant must not disturb the result
    run_op(3, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1);

`ifdef ADDER_ARBITER_SUB_EN
    sub[2] = 1'b1;
    run_op(2, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    sub[2] = 1'b0;
`endif

    // four requesters held high from reset: order 0,1,2,3,0, one done every 3 cycles
    pulse_reset();
    set_ops(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    set_ops(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
    set_ops(3, 32'h1234_5678, 32'h1111_1111, 1'b1);
    push_exp(0, 32'h0000_0030, 1'b0, 1'b0);
    push_exp(1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    push_exp(2, 32'h0000_0000, 1'b1, 1'b1);
    push_exp(3, 32'h2345_678A, 1'b0, 1'b0);
    push_exp(0, 32'h0000_0030, 1'b0, 1'b0);
    req = '1;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      wait_done(t_now);
      if (k > 0) check("done_spacing", 64'(t_now - t_prev), 64'd3);
      t_prev = t_now;
      if (k == 4) req = '0;
    end
    repeat (2) @(negedge Clock);
    check("rr_drained", 64'(exp_q.size()), 64'd0);

    // reset in the EXEC cycle aborts; next grant goes to requester 0, requester 1 withdraws before grant
    set_ops(2, 32'h0000_0001, 32'h0000_0001, 1'b0);
    req[2] = 1'b1;
    @(negedge Clock);
    check("abort_grant", 64'(grant), 64'b0100);
    Reset = 1'b1;
    req[2] = 1'b0;
    #1;
    check("abort_grant_rst", 64'(grant), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_s", 64'(S), 64'd0);
    check("abort_cout", 64'(carryout), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("abort_no_done", 64'(done), 64'd0);

    set_ops(0, 32'h0000_0100, 32'h0000_0200, 1'b1);
    set_ops(1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    push_exp(0, 32'h0000_0301, 1'b0, 1'b0);
    req = 4'b0011;
    @(negedge Clock);
    check("post_rst_grant", 64'(grant), 64'b0001);
    req[1] = 1'b0;
    @(negedge Clock);
    check("post_rst_done", 64'(done), 64'b0001);
    req[0] = 1'b0;
    repeat (4) @(negedge Clock);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
